// File: rtl/neuron_mac_seq_pkg.sv
// Shared constants for the neuron MAC sequencer: ALU opcodes, default width,
// and the sequencer state encoding.
package neuron_mac_seq_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MUL  = 3'd2,
        ST_ACC  = 3'd3,
        ST_BIAS = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

endpackage

// File: rtl/neuron_mac_seq.sv
// Purpose: sequences one neuron, out = bias + sum(x_i*w_i), through an external combinational ALU.
// Latency: 3 cycles per pair (LOAD/MUL/ACC) plus BIAS; result valid 3N+2 cycles after start is raised.
// Backpressure: in_ready only in LOAD; out_data held in OUT until out_ready, unbounded stall.
// Optional: define NEURON_MAC_RELU_EN to clamp negative results to zero in the BIAS stage.
module neuron_mac_seq
    import neuron_mac_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_INPUTS = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_inputs,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    output logic              alu_en,
    output logic [1:0]        alu_op_sel,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   x_q, w_q, prod_q, acc_q, bias_q, out_q;
    logic [CNT_W-1:0]    cnt_q, n_q;
    logic [CNT_W-1:0]    n_clamp;
    logic [DATA_W-1:0]   bias_res;

    assign n_clamp = (num_inputs > CNT_W'(MAX_INPUTS)) ? CNT_W'(MAX_INPUTS) : num_inputs;

`ifdef NEURON_MAC_RELU_EN
    assign bias_res = alu_result[DATA_W-1] ? '0 : alu_result;
`else
    assign bias_res = alu_result;
`endif

    assign out_data = out_q;

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        alu_en     = 1'b0;
        alu_op_sel = ALU_OP_ADD;
        alu_op1    = '0;
        alu_op2    = '0;
        out_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n_clamp == '0) ? ST_BIAS : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                alu_en     = 1'b1;
                alu_op_sel = ALU_OP_MUL;
                alu_op1    = x_q;
                alu_op2    = w_q;
                state_d    = ST_ACC;
            end
            ST_ACC: begin
                alu_en     = 1'b1;
                alu_op_sel = ALU_OP_ADD;
                alu_op1    = acc_q;
                alu_op2    = prod_q;
                state_d    = (cnt_q + CNT_W'(1) == n_q) ? ST_BIAS : ST_LOAD;
            end
            ST_BIAS: begin
                alu_en     = 1'b1;
                alu_op_sel = ALU_OP_ADD;
                alu_op1    = acc_q;
                alu_op2    = bias_q;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                // start arriving alongside the handshake is dropped: IDLE is entered only after this edge
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            w_q     <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            bias_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bias_q <= bias;
                        n_q    <= n_clamp;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        x_q <= in_x;
                        w_q <= in_w;
                    end
                end
                ST_MUL: prod_q <= alu_result;
                ST_ACC: begin
                    acc_q <= alu_result;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_BIAS: out_q <= bias_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq with an integer-stub ALU and a
// behavioural neuron model (sum of products plus bias, wrapped to 16 bits).
module tb_neuron_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  num_inputs;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x, in_w;
    logic        alu_en;
    logic [1:0]  alu_op_sel;
    logic [15:0] alu_op1, alu_op2, alu_result;
    logic        busy, out_valid, out_ready;
    logic [15:0] out_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cnt = 0;
    int rise_cyc = -1;
    bit in_neuron = 1'b0;
    logic prev_ov = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] last_out = '0;
    logic [15:0] exp_q[$];
    logic [15:0] xs[0:31];
    logic [15:0] ws[0:31];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_inputs(num_inputs), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .alu_en(alu_en), .alu_op_sel(alu_op_sel), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    // Integer stub of the ALU: 16-bit wrapping multiply and add.
    always_comb begin
        alu_result = '0;
        if (alu_en) begin
            if (alu_op_sel == 2'b10) alu_result = 16'(alu_op1 * alu_op2);
            else if (alu_op_sel == 2'b00) alu_result = 16'(alu_op1 + alu_op2);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model(input int n, input logic [15:0] b);
        int s;
        logic [15:0] r;
        s = int'(b);
        for (int i = 0; i < n; i++) s = s + int'(xs[i]) * int'(ws[i]);
        r = s[15:0];
`ifdef NEURON_MAC_RELU_EN
        if (r[15]) r = '0;
`endif
        return r;
    endfunction

    // Compare process: output handshakes against the model queue, plus protocol rules.
    always @(negedge clk) begin
        if (in_valid && in_ready) hs_cnt++;
        if (in_neuron) chk("busy_during_neuron", {31'd0, busy}, 32'd1);
        if (in_ready || out_valid) chk("busy_when_active", {31'd0, busy}, 32'd1);
        if (!alu_en) chk("alu_idle_drive", {alu_op_sel, alu_op1, alu_op2}, 32'd0);
        if (out_valid && prev_ov) chk("out_data_stable", {16'd0, out_data}, {16'd0, prev_data});
        if (out_valid && !prev_ov) rise_cyc = cyc;
        if (out_valid && out_ready) begin
            last_out = out_data;
            if (exp_q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
            else chk("out_data_model", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
        end
        prev_ov   = out_valid;
        prev_data = out_data;
    end

    task automatic do_neuron(input int n_req, input logic [15:0] b, input int gap_lo, input int gap_hi,
                             input int bp_lo, input int bp_hi, input bit chk_lat, input bit poke,
                             input int lit);
        int n, e0, k;
        bit hs;
        n = (n_req > 16) ? 16 : n_req;
        exp_q.push_back(model(n, b));
        hs_cnt = 0;
        start = 1'b1; num_inputs = 5'(n_req); bias = b;
        e0 = cyc;
        tick();
        start = 1'b0; num_inputs = 5'($urandom_range(0, 31)); bias = 16'($urandom);
        in_neuron = 1'b1;
        in_valid = 1'b1; in_x = 16'($urandom); in_w = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(gap_lo, gap_hi);
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) tick();
            end
            if (poke && i == 1) begin
                start = 1'b1; num_inputs = 5'd3; bias = 16'hAAAA;
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1; in_x = xs[i]; in_w = ws[i];
            k = 0;
            do begin
                hs = in_ready;
                tick();
                k++;
            end while (!hs && k < 50);
            if (!hs) begin
                chk("in_handshake_timeout", 32'd0, 32'd1);
                in_valid = 1'b0; in_neuron = 1'b0;
                return;
            end
            in_x = 16'($urandom); in_w = 16'($urandom);
        end
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
            in_valid = 1'b0; in_neuron = 1'b0;
            return;
        end
        repeat ($urandom_range(bp_lo, bp_hi)) tick();
        out_ready = 1'b1;
        if (poke) begin
            start = 1'b1; num_inputs = 5'd1; bias = 16'h5555;
        end
        tick();
        out_ready = 1'b0; start = 1'b0; in_valid = 1'b0; in_neuron = 1'b0;
        chk("idle_after_out", {30'd0, busy, out_valid}, 32'd0);
        chk("pair_handshakes", hs_cnt, n);
        if (chk_lat) chk("out_valid_latency", rise_cyc - e0, 3 * n + 2);
        if (lit >= 0) chk("literal_result", {16'd0, last_out}, lit);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_inputs = '0; bias = '0;
        in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {in_ready, alu_en, alu_op_sel, busy, out_valid, out_data},
            32'd0);
        chk("reset_alu_ops", {alu_op1, alu_op2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        xs[0] = 16'd3; ws[0] = 16'd4; xs[1] = 16'd2; ws[1] = 16'd10;
        do_neuron(2, 16'd5, 0, 0, 0, 0, 1'b1, 1'b0, 37);

        do_neuron(0, 16'h1234, 0, 0, 0, 2, 1'b1, 1'b0, 32'h1234);

        for (int i = 0; i < 3; i++) begin xs[i] = 16'd1; ws[i] = 16'd1; end
        do_neuron(3, 16'd0, 4, 4, 5, 5, 1'b0, 1'b0, 3);

        xs[0] = 16'h4000; ws[0] = 16'd2;
        do_neuron(1, 16'h8000, 0, 0, 0, 0, 1'b1, 1'b0, 0);

        xs[0] = 16'd1; ws[0] = 16'd1;
`ifdef NEURON_MAC_RELU_EN
        do_neuron(1, 16'hFFFE, 0, 0, 0, 0, 1'b1, 1'b0, 0);
`else
        do_neuron(1, 16'hFFFE, 0, 0, 0, 0, 1'b1, 1'b0, 32'hFFFF);
`endif

        // Abort in the middle of an ACC cycle: no partial result may escape.
        for (int i = 0; i < 4; i++) begin xs[i] = 16'(i + 2); ws[i] = 16'(i + 5); end
        start = 1'b1; num_inputs = 5'd4; bias = 16'd9;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_x = xs[i]; in_w = ws[i];
            tick();
            tick();
            if (i == 0) tick();
        end
        chk("in_acc_before_reset", {alu_en, alu_op_sel, alu_op2}, {1'b1, 2'b00, 16'(xs[1] * ws[1])});
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {in_ready, alu_en, alu_op_sel, busy, out_valid, out_data},
            32'd0);
        chk("async_reset_alu_ops", {alu_op1, alu_op2}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        xs[0] = 16'd7; ws[0] = 16'd7;
        do_neuron(1, 16'd0, 0, 0, 0, 1, 1'b1, 1'b0, 49);

        for (int i = 0; i < 32; i++) begin xs[i] = 16'($urandom_range(0, 40)); ws[i] = 16'($urandom); end
        do_neuron(31, 16'h0101, 0, 1, 0, 2, 1'b0, 1'b1, -1);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 32; i++) begin xs[i] = 16'($urandom); ws[i] = 16'($urandom); end
            do_neuron($urandom_range(0, 20), 16'($urandom), 0, 2, 0, 3,
                      1'b0, ($urandom_range(0, 3) == 0), -1);
        end

        chk("model_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Sequencer that computes one autoencoder neuron: out = bias + Σ(x_i·w_i), i = 0..num_inputs-1.
- Accepts (x,w) pairs over a valid/ready stream.
- Drives the combinational ALU directly: MUL, then ADD into a local accumulator.
- Presents the result on a valid/ready output port; sits directly upstream of the ALU.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- MAX_INPUTS, 16, largest num_inputs honoured.
- CNT_W, 5, width of num_inputs and of the pair counter; must satisfy 2^CNT_W > MAX_INPUTS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a neuron when idle.
- num_inputs  in  CNT_W  pair count; latched on start.
- bias  in  DATA_W  bias term; latched on start.
- in_valid  in  1  pair available.
- in_ready  out  1  block accepts a pair.
- in_x  in  DATA_W  activation.
- in_w  in  DATA_W  weight.
- alu_en  out  1  drives ALU enable_ALU.
- alu_op_sel  out  2  drives ALU op_select (00 add, 10 mul).
- alu_op1  out  DATA_W  drives ALU Operand_1.
- alu_op2  out  DATA_W  drives ALU Operand_2.
- alu_result  in  DATA_W  ALU result, combinational in the same cycle.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  neuron result.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE.
  - Accumulator, product register, counter and latched num_inputs/bias = 0.
  - All outputs = 0.
  - Reset asserted mid-operation aborts the neuron; no partial result is ever emitted.
- States: IDLE, LOAD, MUL, ACC, BIAS, OUT.
- IDLE:
  - On start: latch bias, latch num_inputs (clamped to MAX_INPUTS), clear accumulator and counter.
  - Next state: BIAS if the clamped count is 0, else LOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready: capture x and w, go to MUL.
  - Otherwise stay in LOAD.
- MUL:
  - Drive alu_en=1, alu_op_sel=10, op1=x, op2=w.
  - Register alu_result into the product register at the clock edge; go to ACC.
- ACC:
  - Drive alu_en=1, alu_op_sel=00, op1=acc, op2=product.
  - Register alu_result into acc; increment counter.
  - If counter+1 == count, go to BIAS; else go to LOAD.
- BIAS:
  - Drive alu_en=1, alu_op_sel=00, op1=acc, op2=bias.
  - Register alu_result into out_data; go to OUT.
- OUT:
  - out_valid = 1 and out_data held stable until out_valid && out_ready.
  - Then clear out_valid and go to IDLE.
  - Backpressure on out_ready is unlimited.
- ALU drive outside MUL/ACC/BIAS: alu_en = 0, alu_op_sel = 00, operands = 0.
- Throughput: 3 cycles per pair when in_valid is held high.
  - out_valid rises 3·N + 2 cycles after the start edge (N = clamped count).
  - N = 0: out_valid rises 2 cycles after start and out_data = bias.
- Arithmetic:
  - Block is format-agnostic; all arithmetic is the ALU's.
  - Accumulation is DATA_W two's-complement and wraps on overflow; no saturation unless RELU_EN is defined.
- Ignored inputs:
  - start while busy is ignored.
  - in_valid outside LOAD is ignored; in_ready is 0 there.
- Simultaneous events: in OUT, start in the same cycle as the out handshake is ignored. A new start is accepted only in IDLE.

Optional Feature:
- Macro: NEURON_MAC_RELU_EN.
- Defined: BIAS stage applies ReLU before registering out_data — if alu_result[DATA_W-1] = 1, out_data = 0, else out_data = alu_result.
- Undefined: out_data = raw alu_result. No other timing changes in either case.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_MUL=2'b10.
  - DATA_W default.
  - State encoding typedef/localparams for the six states.
- Single module; no sub-module is natural. The FSM and datapath registers are small and tightly coupled.
- The top level instantiates neuron_mac_seq next to the ALU and wires them port-to-port.

Test Plan:
- Bench wiring: integer-stub ALU (mul = low 16 bits of integer product, add = 16-bit wrap), plus one pass against the real ALU.
- Scenarios:
  - Basic: start, N=2, bias=5, pairs (3,4),(2,10), in_valid always high -> out_data=37, out_valid rises at cycle 8 after start.
  - N=0, bias=0x1234 -> out_valid 2 cycles after start, out_data=0x1234, in_ready never asserted.
  - Stalls and backpressure: N=3, all pairs (1,1), bias=0, 4-cycle in_valid gaps, out_ready low 5 cycles -> out_data=3 held stable, single handshake, busy high throughout.
  - Wrap: N=1, pair (0x4000,2), bias=0x8000 -> out_data=0x0000 (wrap); with NEURON_MAC_RELU_EN, pair (1,1), bias=0xFFFE -> out_data=0 instead of 0xFFFF.
  - rst_n pulsed low mid-ACC of N=4 -> all outputs 0 at once, state IDLE; next start with N=1, (7,7), bias 0 -> 49.
  - Clamp and ignore: num_inputs=31 with MAX_INPUTS=16 -> exactly 16 handshakes; start pulsed while busy -> no effect on result.
